// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer-width helper, default count width and
// the status bundle reused by the synchronous, async and multi-channel FIFOs.
package fifo_pkg;

  // Ceiling log2 for parameter arithmetic; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEFAULT_DEPTH = 16;
  // Occupancy needs one bit more than the address to represent DEPTH itself.
  localparam int unsigned DEFAULT_CNT_W = clog2(DEFAULT_DEPTH) + 1;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, combinational read port.
// Not reset; contents are masked by the FIFO's empty state.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: one entry per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock first-word-fall-through FIFO with occupancy
// count and almost-full/almost-empty thresholds.
// Optional feature macro: SYNC_FIFO_ERR_EN enables sticky overflow/underflow
// flags; without it io_overflow/io_underflow are tied low.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] io_din,
  input  logic                  io_push,
  input  logic                  io_pop,
  output logic [DATA_WIDTH-1:0] io_dout,
  output logic                  io_empty,
  output logic                  io_full,
  output logic [clog2(DEPTH):0] io_count,
  output logic                  io_almost_full,
  output logic                  io_almost_empty,
  output logic                  io_overflow,
  output logic                  io_underflow
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] AF_LVL = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_LVL = CW'(AEMPTY_THRESH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [CW-1:0]         count;
  logic                  push_ok;
  logic                  pop_ok;
  logic [DATA_WIDTH-1:0] rdata;
  fifo_status_t          status;

  // Status is purely combinational from the pointers.
  always_comb begin
    count               = wr_ptr - rd_ptr;
    status.empty        = (wr_ptr == rd_ptr);
    status.full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                          (wr_ptr[AW] != rd_ptr[AW]);
    status.almost_full  = (count >= AF_LVL);
    status.almost_empty = (count <= AE_LVL);
  end

  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  assign push_ok = io_push & (~status.full | io_pop);
  assign pop_ok  = io_pop & ~status.empty;

  // Pointer update; wrap bit falls out of the natural AW+1-bit rollover.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok & ~reset),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (io_din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign io_dout         = status.empty ? '0 : rdata;
  assign io_empty        = status.empty;
  assign io_full         = status.full;
  assign io_count        = count;
  assign io_almost_full  = status.almost_full;
  assign io_almost_empty = status.almost_empty;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow;
  logic underflow;

  // Sticky error capture, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (io_push & status.full & ~io_pop) overflow  <= 1'b1;
      if (io_pop & status.empty)           underflow <= 1'b1;
    end
  end

  assign io_overflow  = overflow;
  assign io_underflow = underflow;
`else
  assign io_overflow  = 1'b0;
  assign io_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a short table of hand-computed
// vectors, hand-written corner sequences and a random stress phase, all
// checked against a queue scoreboard after every clock edge.
module tb_sync_fifo_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] io_din;
  logic          io_push;
  logic          io_pop;
  logic [DW-1:0] io_dout;
  logic          io_empty;
  logic          io_full;
  logic [4:0]    io_count;
  logic          io_almost_full;
  logic          io_almost_empty;
  logic          io_overflow;
  logic          io_underflow;

  int checks = 0;
  int errors = 0;

  // Scoreboard: queue of expected entries plus expected sticky flags.
  logic [DW-1:0] sb[$];
  logic          ovf_m;
  logic          unf_m;

  sync_fifo_param #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_din          (io_din),
    .io_push         (io_push),
    .io_pop          (io_pop),
    .io_dout         (io_dout),
    .io_empty        (io_empty),
    .io_full         (io_full),
    .io_count        (io_count),
    .io_almost_full  (io_almost_full),
    .io_almost_empty (io_almost_empty),
    .io_overflow     (io_overflow),
    .io_underflow    (io_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against the scoreboard.
  task automatic check_model(input string tag);
    int n;
    n = sb.size();
    chk({tag, " count"},  int'(io_count), n);
    chk({tag, " empty"},  int'(io_empty), int'(n == 0));
    chk({tag, " full"},   int'(io_full), int'(n == DEPTH));
    chk({tag, " afull"},  int'(io_almost_full), int'(n >= AF));
    chk({tag, " aempty"}, int'(io_almost_empty), int'(n <= AE));
    chk({tag, " dout"},   int'(io_dout), (n == 0) ? 0 : int'(sb[0]));
    chk({tag, " ovf"},    int'(io_overflow), int'(ovf_m));
    chk({tag, " unf"},    int'(io_underflow), int'(unf_m));
  endtask

  // One clock: drive, update the scoreboard from pre-edge state, then check.
  task automatic step(input logic rst, input logic push, input logic pop,
                      input logic [DW-1:0] din, input string tag);
    int  n;
    logic pop_acc;
    logic push_acc;
    reset   = rst;
    io_push = push;
    io_pop  = pop;
    io_din  = din;
    @(posedge clk);
    n = sb.size();
    if (rst) begin
      sb.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      pop_acc  = pop && (n != 0);
      push_acc = push && ((n != DEPTH) || pop);
`ifdef SYNC_FIFO_ERR_EN
      if (push && (n == DEPTH) && !pop) ovf_m = 1'b1;
      if (pop && (n == 0))              unf_m = 1'b1;
`endif
      if (pop_acc)  void'(sb.pop_front());
      if (push_acc) sb.push_back(din);
    end
    #1;
    reset   = 1'b0;
    io_push = 1'b0;
    io_pop  = 1'b0;
    check_model(tag);
  endtask

  typedef struct {
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    int            exp_count;
    int            exp_dout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    reset   = 1'b1;
    io_push = 1'b0;
    io_pop  = 1'b0;
    io_din  = '0;
    ovf_m   = 1'b0;
    unf_m   = 1'b0;

    // Reset with push/pop asserted: both must be ignored.
    step(1'b1, 1'b1, 1'b1, 8'hEE, "reset");
    step(1'b0, 1'b0, 1'b0, 8'h00, "idle");

    // Hand-computed vectors: latency, FWFT head, push+pop, empty corner.
    vecs[0] = '{1'b1, 1'b0, 8'hA1, 1, 8'hA1};
    vecs[1] = '{1'b1, 1'b0, 8'hA2, 2, 8'hA1};
    vecs[2] = '{1'b1, 1'b1, 8'hA3, 2, 8'hA2};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 1, 8'hA3};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 8'h11, 1, 8'h11};
    for (int i = 0; i < 7; i++) begin
      step(1'b0, vecs[i].push, vecs[i].pop, vecs[i].din, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tcount", i), int'(io_count), vecs[i].exp_count);
      chk($sformatf("vec%0d tdout", i), int'(io_dout), vecs[i].exp_dout);
    end
`ifdef SYNC_FIFO_ERR_EN
    chk("underflow sticky", int'(io_underflow), 1);
`else
    chk("underflow tied", int'(io_underflow), 0);
`endif

    // Fill from empty: 0x00..0x0F, almost_full edge at 14.
    step(1'b1, 1'b0, 1'b0, 8'h00, "reset2");
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i), $sformatf("fill%0d", i));
      if (i == 12) chk("afull below thresh", int'(io_almost_full), 0);
      if (i == 13) chk("afull at thresh", int'(io_almost_full), 1);
    end
    chk("full after fill", int'(io_full), 1);
    chk("count after fill", int'(io_count), 16);

    // Full: push+pop replaces head, appends 0xAA, no overflow.
    step(1'b0, 1'b1, 1'b1, 8'hAA, "full pushpop");
    chk("pushpop count", int'(io_count), 16);
    chk("pushpop dout", int'(io_dout), 8'h01);
    chk("pushpop ovf", int'(io_overflow), 0);

    // Full: push without pop is dropped.
    step(1'b0, 1'b1, 1'b0, 8'h55, "full push");
    chk("drop count", int'(io_count), 16);
`ifdef SYNC_FIFO_ERR_EN
    chk("overflow set", int'(io_overflow), 1);
`else
    chk("overflow tied", int'(io_overflow), 0);
`endif

    // Drain: order 0x01..0x0F then 0xAA, never 0x55.
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain head%0d", i), int'(io_dout), (i < 15) ? (i + 1) : 8'hAA);
      step(1'b0, 1'b0, 1'b1, 8'h00, $sformatf("drain%0d", i));
    end
    chk("empty after drain", int'(io_empty), 1);

    // Random stress across several pointer wraps.
    for (int i = 0; i < 3 * DEPTH * 2; i++) begin
      logic p;
      logic q;
      p = ($urandom_range(0, 99) < 60);
      q = ($urandom_range(0, 99) < 45);
      step(1'b0, p, q, 8'($urandom), "rand");
    end
    // Bring to half-full, then reset mid-operation.
    while (sb.size() > DEPTH / 2) step(1'b0, 1'b0, 1'b1, 8'h00, "trim");
    while (sb.size() < DEPTH / 2) step(1'b0, 1'b1, 1'b0, 8'($urandom), "grow");
    step(1'b1, 1'b1, 1'b1, 8'h77, "mid reset");
    chk("reset empty", int'(io_empty), 1);
    chk("reset count", int'(io_count), 0);
    step(1'b0, 1'b0, 1'b0, 8'h00, "post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
